// File: rtl/wcoder_pkg.sv
// Shared definitions for the wcoder pixel capture/packer.
//  - state_e       : packer FSM states
//  - SOF_BIT/EOL_BIT: tag bit positions in a FIFO entry (tags sit below the data)
//  - TAG_W         : number of tag bits per FIFO entry
//  - DW_DEFAULT/PACK_DEFAULT: default pixel width and pixels per word
package wcoder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StVblank,
        StFrame
    } state_e;

    localparam int unsigned SOF_BIT      = 0;
    localparam int unsigned EOL_BIT      = 1;
    localparam int unsigned TAG_W        = 2;

    localparam int unsigned DW_DEFAULT   = 8;
    localparam int unsigned PACK_DEFAULT = 4;

endpackage

// File: rtl/wcoder_fifo.sv
// First-word-fall-through FIFO with a two-word push port and one-word pop.
// Ports:
//  clk       in   clock, rising edge
//  rst       in   synchronous reset, active high
//  push0     in   write wdata0
//  push1     in   write wdata1 behind wdata0 (only meaningful with push0)
//  wdata0/1  in   WIDTH-bit entries
//  pop       in   remove head entry (ignored when empty)
//  rdata     out  head entry, zero when empty
//  ready     out  FIFO non-empty
//  overflow  out  sticky: an entry was dropped because no slot was free
module wcoder_fifo
    import wcoder_pkg::*;
#(
    parameter int unsigned WIDTH = PACK_DEFAULT * DW_DEFAULT + TAG_W,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push0,
    input  logic             push1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             ready,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          overflow_q;
    logic [AW:0]   used;
    logic [AW+1:0] avail;
    logic          empty;
    logic          pop_eff;
    logic          acc0;
    logic          acc1;
    logic [AW-1:0] widx0;
    logic [AW-1:0] widx1;

    always_comb begin
        used    = wptr_q - rptr_q;
        empty   = (used == '0);
        pop_eff = pop && !empty;
        // A pop on the same edge frees its slot for an incoming word.
        avail   = (AW+2)'(DEPTH) - {1'b0, used} + {{(AW+1){1'b0}}, pop_eff};
        acc0    = push0 && (avail >= (AW+2)'(1));
        acc1    = push1 && acc0 && (avail >= (AW+2)'(2));
        widx0   = wptr_q[AW-1:0];
        widx1   = widx0 + AW'(1);
        wptr_d  = wptr_q + (AW+1)'(acc0) + (AW+1)'(acc1);
        rptr_d  = rptr_q + (AW+1)'(pop_eff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if ((push0 && !acc0) || (push1 && !acc1)) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the output is masked while empty.
    always_ff @(posedge clk) begin
        if (acc0) begin
            mem[widx0] <= wdata0;
        end
        if (acc1) begin
            mem[widx1] <= wdata1;
        end
    end

    assign rdata    = empty ? '0 : mem[rptr_q[AW-1:0]];
    assign ready    = !empty;
    assign overflow = overflow_q;

endmodule

// File: rtl/wcoder_pack.sv
// Camera-side pixel capture and packer. Captures DW-bit pixels while hsync is
// high inside a frame, packs PACK pixels per word (first pixel in the LSBs) and
// queues words with start-of-frame / end-of-line tags in a FWFT FIFO.
// Ports:
//  pclk      in   pixel clock, rising edge
//  rst       in   synchronous reset, active high
//  vsync     in   high = vertical blanking; falling edge starts a frame
//  hsync     in   high = pixel valid
//  din       in   pixel data
//  ready     out  FIFO non-empty; dout/tags valid
//  rd        in   pop head word (ignored when ready=0)
//  dout      out  head word
//  dout_sof  out  head word is first word of frame
//  dout_eol  out  head word is last word of a line
//  line_cnt  out  lines completed in the current frame (saturating)
//  overflow  out  sticky: a word was dropped on a full FIFO
module wcoder_pack
    import wcoder_pkg::*;
#(
    parameter int unsigned DW    = DW_DEFAULT,
    parameter int unsigned PACK  = PACK_DEFAULT,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LCW   = 16
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               vsync,
    input  logic               hsync,
    input  logic [DW-1:0]      din,
    output logic               ready,
    input  logic               rd,
    output logic [PACK*DW-1:0] dout,
    output logic               dout_sof,
    output logic               dout_eol,
    output logic [LCW-1:0]     line_cnt,
    output logic               overflow
);

    localparam int unsigned PW = PACK * DW;
    localparam int unsigned FW = PW + TAG_W;
    localparam int unsigned CW = (PACK > 1) ? $clog2(PACK) : 1;

    state_e         state_q, state_d;
    logic           hsync_q, vsync_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  word_q, word_d;
    logic [PW-1:0]  hold_q, hold_d;
    logic           hold_sof_q, hold_sof_d;
    logic           hold_vld_q, hold_vld_d;
    logic           sof_pend_q, sof_pend_d;
    logic [LCW-1:0] line_cnt_q, line_cnt_d;

    logic           push0, push1;
    logic [FW-1:0]  wdata0, wdata1;
    logic [FW-1:0]  rdata;
    logic [PW-1:0]  word_new;
    logic           hsync_fall, vsync_rise, flush;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        hold_d     = hold_q;
        hold_sof_d = hold_sof_q;
        hold_vld_d = hold_vld_q;
        sof_pend_d = sof_pend_q;
        line_cnt_d = line_cnt_q;
        push0      = 1'b0;
        push1      = 1'b0;
        wdata0     = '0;
        wdata1     = '0;
        word_new   = word_q;

        hsync_fall = hsync_q && !hsync;
        vsync_rise = vsync && !vsync_q;
        // A frame ending mid-line closes that line like an hsync fall.
        flush      = hsync_fall || (vsync_rise && hsync);

        unique case (state_q)
            StIdle: begin
                if (vsync) begin
                    state_d = StVblank;
                end
            end

            StVblank: begin
                if (!vsync) begin
                    state_d    = StFrame;
                    sof_pend_d = 1'b1;
                    line_cnt_d = '0;
                end
            end

            StFrame: begin
                if (hsync && !vsync) begin
                    // The held word is now known not to end the line.
                    if (hold_vld_q) begin
                        push0                        = 1'b1;
                        wdata0[TAG_W +: PW]          = hold_q;
                        wdata0[SOF_BIT]              = hold_sof_q;
                        wdata0[EOL_BIT]              = 1'b0;
                        hold_vld_d                   = 1'b0;
                    end
                    word_new[32'(cnt_q) * DW +: DW] = din;
                    if (cnt_q == CW'(PACK - 1)) begin
                        hold_d     = word_new;
                        hold_sof_d = sof_pend_q;
                        hold_vld_d = 1'b1;
                        sof_pend_d = 1'b0;
                        cnt_d      = '0;
                        word_d     = '0;
                    end else begin
                        word_d = word_new;
                        cnt_d  = cnt_q + CW'(1);
                    end
                end else if (flush) begin
                    if (hold_vld_q && (cnt_q != '0)) begin
                        push0               = 1'b1;
                        wdata0[TAG_W +: PW] = hold_q;
                        wdata0[SOF_BIT]     = hold_sof_q;
                        wdata0[EOL_BIT]     = 1'b0;
                        push1               = 1'b1;
                        wdata1[TAG_W +: PW] = word_q;
                        wdata1[SOF_BIT]     = sof_pend_q;
                        wdata1[EOL_BIT]     = 1'b1;
                        sof_pend_d          = 1'b0;
                    end else if (hold_vld_q) begin
                        push0               = 1'b1;
                        wdata0[TAG_W +: PW] = hold_q;
                        wdata0[SOF_BIT]     = hold_sof_q;
                        wdata0[EOL_BIT]     = 1'b1;
                    end else if (cnt_q != '0) begin
                        // Upper lanes of word_q are still zero from the last clear.
                        push0               = 1'b1;
                        wdata0[TAG_W +: PW] = word_q;
                        wdata0[SOF_BIT]     = sof_pend_q;
                        wdata0[EOL_BIT]     = 1'b1;
                        sof_pend_d          = 1'b0;
                    end
                    hold_vld_d = 1'b0;
                    cnt_d      = '0;
                    word_d     = '0;
                    line_cnt_d = (&line_cnt_q) ? line_cnt_q : line_cnt_q + LCW'(1);
                end
                if (vsync) begin
                    state_d = StVblank;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q    <= StIdle;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            cnt_q      <= '0;
            word_q     <= '0;
            hold_q     <= '0;
            hold_sof_q <= 1'b0;
            hold_vld_q <= 1'b0;
            sof_pend_q <= 1'b0;
            line_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hsync_q    <= hsync;
            vsync_q    <= vsync;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            hold_q     <= hold_d;
            hold_sof_q <= hold_sof_d;
            hold_vld_q <= hold_vld_d;
            sof_pend_q <= sof_pend_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    wcoder_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (pclk),
        .rst      (rst),
        .push0    (push0),
        .push1    (push1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .pop      (rd),
        .rdata    (rdata),
        .ready    (ready),
        .overflow (overflow)
    );

    assign dout     = rdata[TAG_W +: PW];
    assign dout_sof = rdata[SOF_BIT];
    assign dout_eol = rdata[EOL_BIT];
    assign line_cnt = line_cnt_q;

endmodule

// File: tb/tb_wcoder_pack.sv
// Bench for wcoder_pack (DW=8, PACK=4, DEPTH=4). Expected words come from a
// line-level model: a line's pixels are cut into PACK-pixel chunks, the last
// chunk zero-padded and tagged eol, the first word of a frame tagged sof.
module tb_wcoder_pack;

    localparam int unsigned DW    = 8;
    localparam int unsigned PACK  = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LCW   = 16;

    logic               pclk;
    logic               rst;
    logic               vsync;
    logic               hsync;
    logic [DW-1:0]      din;
    logic               ready;
    logic               rd;
    logic [PACK*DW-1:0] dout;
    logic               dout_sof;
    logic               dout_eol;
    logic [LCW-1:0]     line_cnt;
    logic               overflow;

    wcoder_pack #(
        .DW    (DW),
        .PACK  (PACK),
        .DEPTH (DEPTH),
        .LCW   (LCW)
    ) dut (
        .pclk     (pclk),
        .rst      (rst),
        .vsync    (vsync),
        .hsync    (hsync),
        .din      (din),
        .ready    (ready),
        .rd       (rd),
        .dout     (dout),
        .dout_sof (dout_sof),
        .dout_eol (dout_eol),
        .line_cnt (line_cnt),
        .overflow (overflow)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int errors = 0;
    int checks = 0;

    // Expected FIFO contents as {data, eol, sof}.
    logic [PACK*DW+1:0] expq[$];
    logic [DW-1:0]      line_px[$];
    bit                 mdl_sof;
    int                 mdl_lines;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, check any pop at the falling edge, return 1 after rise.
    task automatic step(input logic hs, input logic vs, input logic r, input logic [7:0] px);
        hsync = hs;
        vsync = vs;
        rd    = r;
        din   = px;
        @(negedge pclk);
        if (r && ready) begin
            if (expq.size() == 0) begin
                chk("pop_unexpected", 64'(ready), 64'(0));
            end else begin
                chk("pop_word", 64'({dout, dout_eol, dout_sof}), 64'(expq[0]));
                void'(expq.pop_front());
            end
        end
        @(posedge pclk);
        #1;
    endtask

    // Fill line_px and append the resulting words to the expectation.
    task automatic build_line(input int n, input bit rnd, input int base, input bit keep);
        int nw;
        logic [PACK*DW-1:0] data;
        line_px.delete();
        for (int i = 0; i < n; i++) begin
            line_px.push_back(rnd ? 8'($urandom) : 8'(base + i));
        end
        nw = (n + PACK - 1) / PACK;
        if (keep) begin
            for (int w = 0; w < nw; w++) begin
                data = '0;
                for (int k = 0; k < PACK; k++) begin
                    if (w * PACK + k < n) begin
                        data = data | (32'(line_px[w * PACK + k]) << (8 * k));
                    end
                end
                expq.push_back({data, (w == nw - 1) ? 1'b1 : 1'b0, mdl_sof});
                mdl_sof = 1'b0;
            end
        end
        mdl_lines++;
    endtask

    task automatic play_line(input bit rnd_rd);
        foreach (line_px[i]) begin
            step(1'b1, 1'b0, rnd_rd ? 1'($urandom) : 1'b0, line_px[i]);
        end
    endtask

    task automatic drain(input logic vs, input bit rnd_rd);
        for (int i = 0; i < 64; i++) begin
            if (!ready && expq.size() == 0) break;
            step(1'b0, vs, rnd_rd ? 1'($urandom) : 1'b1, 8'h00);
        end
        chk("drain_ready", 64'(ready), 64'(0));
        chk("drain_left", 64'(expq.size()), 64'(0));
    endtask

    task automatic frame_start();
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        mdl_sof   = 1'b1;
        mdl_lines = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nl;
        int n;
        bit vend;
        rst   = 1'b1;
        vsync = 1'b0;
        hsync = 1'b0;
        din   = '0;
        rd    = 1'b0;
        @(posedge pclk);
        #1;

        // Reset
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        chk("rst_ready", 64'(ready), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        chk("rst_lines", 64'(line_cnt), 64'(0));
        chk("rst_dout", 64'({dout, dout_eol, dout_sof}), 64'(0));

        // Pixels before any vsync pulse are ignored
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(i + 1));
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("idle_ready", 64'(ready), 64'(0));
        chk("idle_lines", 64'(line_cnt), 64'(0));

        // Full line of 8 pixels
        frame_start();
        build_line(8, 1'b0, 1, 1'b1);
        play_line(1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("full_lines", 64'(line_cnt), 64'(1));
        chk("full_head", 64'({dout, dout_eol, dout_sof}), 64'({32'h04030201, 1'b0, 1'b1}));
        drain(1'b0, 1'b0);

        // Partial line of 6 pixels; both words must be queued back to back
        build_line(6, 1'b0, 1, 1'b1);
        play_line(1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("part_lines", 64'(line_cnt), 64'(2));
        drain(1'b0, 1'b0);

        // Overflow: five one-word lines, no reads; the fifth is dropped
        for (int l = 0; l < 5; l++) begin
            build_line(4, 1'b1, 0, l < 4);
            play_line(1'b0);
            step(1'b0, 1'b0, 1'b0, 8'h00);
        end
        chk("ovf_set", 64'(overflow), 64'(1));
        chk("ovf_lines", 64'(line_cnt), 64'(7));
        drain(1'b0, 1'b0);
        chk("ovf_sticky", 64'(overflow), 64'(1));

        // Full FIFO with a pop on the push edge
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        expq.delete();
        chk("rst2_ovf", 64'(overflow), 64'(0));
        frame_start();
        for (int l = 0; l < 5; l++) begin
            build_line(4, 1'b1, 0, 1'b1);
            play_line(1'b0);
            step(1'b0, 1'b0, l == 4, 8'h00);
        end
        chk("popfull_ovf", 64'(overflow), 64'(0));
        chk("popfull_ready", 64'(ready), 64'(1));
        drain(1'b0, 1'b0);

        // Reset mid-line flushes everything
        build_line(4, 1'b1, 0, 1'b1);
        play_line(1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("pre_rst_ready", 64'(ready), 64'(1));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'(i + 1));
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h04);
        rst = 1'b0;
        expq.delete();
        chk("mrst_ready", 64'(ready), 64'(0));
        chk("mrst_lines", 64'(line_cnt), 64'(0));
        chk("mrst_dout", 64'({dout, dout_eol, dout_sof}), 64'(0));
        for (int i = 4; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(i + 1));
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("mrst_ignored", 64'(ready), 64'(0));
        frame_start();
        build_line(4, 1'b0, 8'h11, 1'b1);
        play_line(1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("mrst_sof", 64'({dout, dout_eol, dout_sof}), 64'({32'h14131211, 1'b1, 1'b1}));
        drain(1'b0, 1'b0);

        // Random frames, random reads, some frames closed by vsync mid-line
        for (int f = 0; f < 8; f++) begin
            frame_start();
            nl = 1 + int'($urandom_range(3));
            vend = 1'b0;
            for (int l = 0; l < nl; l++) begin
                n = 1 + int'($urandom_range(9));
                build_line(n, 1'b1, 0, 1'b1);
                play_line(1'b1);
                if (l == nl - 1 && $urandom_range(1) == 1) begin
                    vend = 1'b1;
                    step(1'b1, 1'b1, 1'($urandom), 8'($urandom));
                    drain(1'b1, 1'b1);
                end else begin
                    step(1'b0, 1'b0, 1'($urandom), 8'h00);
                    drain(1'b0, 1'b1);
                end
            end
            chk(vend ? "rnd_lines_v" : "rnd_lines", 64'(line_cnt), 64'(mdl_lines));
        end
        chk("rnd_ovf", 64'(overflow), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
